// File: rtl/cache_control_nway.sv
// N-way write-back, write-allocate cache controller FSM with invalid-way-first victim selection.
// Define CACHE_CTRL_PERF_EN to build the hit/miss/write-back performance counters.
module cache_control_nway #(
    parameter int WAYS  = 4,
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    input  logic [WAYS-1:0]  hit,
    input  logic [WAYS-1:0]  valid,
    input  logic [WAYS-1:0]  dirty,
    input  logic [WAY_W-1:0] lru_way,
    output logic [WAY_W-1:0] hit_way,
    output logic             lru_update,
    output logic [WAY_W-1:0] victim_way,
    output logic [WAYS-1:0]  cpu_we,
    output logic [WAYS-1:0]  line_we,
    output logic [WAYS-1:0]  valid_we,
    output logic [WAYS-1:0]  dirty_we,
    output logic             dirty_in,
    output logic             pmem_addr_sel,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp,
    output logic [31:0]      perf_hits,
    output logic [31:0]      perf_misses,
    output logic [31:0]      perf_wbs
);

    typedef enum logic [1:0] {
        IDLE,
        TAG_CHECK,
        WRITE_BACK,
        ALLOCATE
    } state_t;

    state_t state;

    logic             any_hit;
    logic             all_valid;
    logic             victim_dirty;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] miss_victim;
    logic [WAYS-1:0]  hit_mask;
    logic [WAYS-1:0]  victim_mask;

    // Descending scan leaves the lowest-index hit and lowest-index invalid way.
    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit[i]) hit_way = WAY_W'(i);
            if (!valid[i]) inv_way = WAY_W'(i);
        end
    end

    assign any_hit      = |hit;
    assign all_valid    = &valid;
    assign miss_victim  = all_valid ? lru_way : inv_way;
    assign victim_dirty = valid[miss_victim] & dirty[miss_victim];
    assign hit_mask     = WAYS'(1) << hit_way;
    assign victim_mask  = WAYS'(1) << victim_way;

    // Same-cycle strobes: they depend on the combinational hit vector and pmem_resp.
    always_comb begin
        mem_resp   = 1'b0;
        lru_update = 1'b0;
        cpu_we     = '0;
        line_we    = '0;
        valid_we   = '0;
        dirty_we   = '0;
        dirty_in   = 1'b0;
        case (state)
            TAG_CHECK: begin
                if (any_hit) begin
                    mem_resp   = 1'b1;
                    lru_update = 1'b1;
                    if (mem_write) begin
                        cpu_we   = hit_mask;
                        dirty_we = hit_mask;
                        dirty_in = 1'b1;
                    end
                end
            end
            ALLOCATE: begin
                if (pmem_resp) begin
                    line_we  = victim_mask;
                    valid_we = victim_mask;
                    dirty_we = victim_mask;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            victim_way    <= '0;
            pmem_read     <= 1'b0;
            pmem_write    <= 1'b0;
            pmem_addr_sel <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) state <= TAG_CHECK;
                end
                TAG_CHECK: begin
                    if (any_hit) begin
                        state <= IDLE;
                    end else begin
                        victim_way <= miss_victim;
                        if (victim_dirty) begin
                            state         <= WRITE_BACK;
                            pmem_write    <= 1'b1;
                            pmem_addr_sel <= 1'b1;
                        end else begin
                            state     <= ALLOCATE;
                            pmem_read <= 1'b1;
                        end
                    end
                end
                WRITE_BACK: begin
                    if (pmem_resp) begin
                        state         <= ALLOCATE;
                        pmem_write    <= 1'b0;
                        pmem_addr_sel <= 1'b0;
                        pmem_read     <= 1'b1;
                    end
                end
                ALLOCATE: begin
                    if (pmem_resp) begin
                        state     <= TAG_CHECK;
                        pmem_read <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_CTRL_PERF_EN
    // The hit that follows a fill belongs to the miss already counted, so it is skipped.
    logic prev_alloc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_alloc  <= 1'b0;
            perf_hits   <= '0;
            perf_misses <= '0;
            perf_wbs    <= '0;
        end else begin
            prev_alloc <= (state == ALLOCATE);
            if (state == TAG_CHECK && any_hit && !prev_alloc && perf_hits != '1)
                perf_hits <= perf_hits + 32'd1;
            if (state == TAG_CHECK && !any_hit && perf_misses != '1)
                perf_misses <= perf_misses + 32'd1;
            if (state == WRITE_BACK && pmem_resp && perf_wbs != '1)
                perf_wbs <= perf_wbs + 32'd1;
        end
    end
`else
    assign perf_hits   = '0;
    assign perf_misses = '0;
    assign perf_wbs    = '0;
`endif

endmodule

// File: tb/tb_cache_control_nway.sv
// Directed self-checking bench for cache_control_nway (WAYS=4) with a response scoreboard
// and a small physical-memory responder folded into the transaction task.
module tb_cache_control_nway;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic        mem_resp;
    logic [3:0]  hit;
    logic [3:0]  valid;
    logic [3:0]  dirty;
    logic [1:0]  lru_way;
    logic [1:0]  hit_way;
    logic        lru_update;
    logic [1:0]  victim_way;
    logic [3:0]  cpu_we;
    logic [3:0]  line_we;
    logic [3:0]  valid_we;
    logic [3:0]  dirty_we;
    logic        dirty_in;
    logic        pmem_addr_sel;
    logic        pmem_read;
    logic        pmem_write;
    logic        pmem_resp;
    logic [31:0] perf_hits;
    logic [31:0] perf_misses;
    logic [31:0] perf_wbs;

    int checks;
    int errors;

    typedef struct {
        logic [1:0] hit_way;
        logic [3:0] cpu_we;
        logic [3:0] dirty_we;
        logic       dirty_in;
        int         latency;
        logic       wb;
        logic       rd;
        logic [3:0] fill;
        logic [1:0] victim;
    } resp_t;

    resp_t exp_q[$];

`ifdef CACHE_CTRL_PERF_EN
    localparam logic [31:0] EXP_HITS   = 32'd3;
    localparam logic [31:0] EXP_MISSES = 32'd2;
    localparam logic [31:0] EXP_WBS    = 32'd1;
`else
    localparam logic [31:0] EXP_HITS   = 32'd0;
    localparam logic [31:0] EXP_MISSES = 32'd0;
    localparam logic [31:0] EXP_WBS    = 32'd0;
`endif

    cache_control_nway #(.WAYS(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_resp      (mem_resp),
        .hit           (hit),
        .valid         (valid),
        .dirty         (dirty),
        .lru_way       (lru_way),
        .hit_way       (hit_way),
        .lru_update    (lru_update),
        .victim_way    (victim_way),
        .cpu_we        (cpu_we),
        .line_we       (line_we),
        .valid_we      (valid_we),
        .dirty_we      (dirty_we),
        .dirty_in      (dirty_in),
        .pmem_addr_sel (pmem_addr_sel),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_resp     (pmem_resp),
        .perf_hits     (perf_hits),
        .perf_misses   (perf_misses),
        .perf_wbs      (perf_wbs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [3:0] h,
                                 input logic [3:0] v, input logic [3:0] d, input logic [1:0] l);
        mem_read  = rd;
        mem_write = wr;
        hit       = h;
        valid     = v;
        dirty     = d;
        lru_way   = l;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic resp_t mkExp(input logic [1:0] hw, input logic [3:0] cw, input logic [3:0] dw,
                                    input logic di, input int lat, input logic wb, input logic rd,
                                    input logic [3:0] fill, input logic [1:0] victim);
        resp_t r;
        r.hit_way  = hw;
        r.cpu_we   = cw;
        r.dirty_we = dw;
        r.dirty_in = di;
        r.latency  = lat;
        r.wb       = wb;
        r.rd       = rd;
        r.fill     = fill;
        r.victim   = victim;
        return r;
    endfunction

    // Drives one CPU request, plays the memory and datapath roles, and scores the response.
    task automatic runTxn(input string tag, input logic rd, input logic wr, input logic [3:0] h,
                          input logic [3:0] v, input logic [3:0] d, input logic [1:0] l,
                          input int plat, input resp_t e);
        int         cyc;
        int         pcnt;
        logic       done;
        logic       fill_next;
        logic       saw_wb;
        logic       saw_rd;
        logic       wb_sel_ok;
        logic       rd_sel_ok;
        logic       both_high;
        logic       fill_dirty_in;
        logic [3:0] fill_line;
        logic [3:0] fill_valid;
        logic [3:0] fill_dirty_we;
        resp_t      g;
        cyc = 0; pcnt = 0; done = 1'b0; fill_next = 1'b0;
        saw_wb = 1'b0; saw_rd = 1'b0; wb_sel_ok = 1'b1; rd_sel_ok = 1'b1; both_high = 1'b0;
        fill_dirty_in = 1'b0; fill_line = '0; fill_valid = '0; fill_dirty_we = '0;
        nextCycle();
        applyStimulus(rd, wr, h, v, d, l);
        pmem_resp = 1'b0;
        exp_q.push_back(e);
        while (!done && cyc <= 40) begin
            #2;
            if (pmem_read && pmem_write) both_high = 1'b1;
            if (pmem_write) begin saw_wb = 1'b1; if (!pmem_addr_sel) wb_sel_ok = 1'b0; end
            if (pmem_read) begin saw_rd = 1'b1; if (pmem_addr_sel) rd_sel_ok = 1'b0; end
            if (|line_we) begin
                fill_line     = line_we;
                fill_valid    = valid_we;
                fill_dirty_we = dirty_we;
                fill_dirty_in = dirty_in;
            end
            if (mem_resp) begin
                done = 1'b1;
                g = exp_q.pop_front();
                checkOutput({tag, "_hit_way"}, 32'(hit_way), 32'(g.hit_way));
                checkOutput({tag, "_lru_update"}, 32'(lru_update), 32'd1);
                checkOutput({tag, "_cpu_we"}, 32'(cpu_we), 32'(g.cpu_we));
                checkOutput({tag, "_dirty_we"}, 32'(dirty_we), 32'(g.dirty_we));
                checkOutput({tag, "_dirty_in"}, 32'(dirty_in), 32'(g.dirty_in));
                checkOutput({tag, "_latency"}, 32'(cyc), 32'(g.latency));
                checkOutput({tag, "_saw_pmem_write"}, 32'(saw_wb), 32'(g.wb));
                checkOutput({tag, "_saw_pmem_read"}, 32'(saw_rd), 32'(g.rd));
                checkOutput({tag, "_wb_addr_sel"}, 32'(wb_sel_ok), 32'd1);
                checkOutput({tag, "_rd_addr_sel"}, 32'(rd_sel_ok), 32'd1);
                checkOutput({tag, "_pmem_both_high"}, 32'(both_high), 32'd0);
                checkOutput({tag, "_fill_line_we"}, 32'(fill_line), 32'(g.fill));
                checkOutput({tag, "_fill_valid_we"}, 32'(fill_valid), 32'(g.fill));
                checkOutput({tag, "_fill_dirty_we"}, 32'(fill_dirty_we), 32'(g.fill));
                checkOutput({tag, "_fill_dirty_in"}, 32'(fill_dirty_in), 32'd0);
                checkOutput({tag, "_victim_way"}, 32'(victim_way), 32'(g.victim));
            end else begin
                fill_next = pmem_read && pmem_resp;
                nextCycle();
                cyc++;
                if (fill_next) begin
                    hit   = fill_line;
                    valid = valid | fill_line;
                end
                if (pmem_read || pmem_write) begin
                    pcnt++;
                    pmem_resp = (pcnt == plat);
                    if (pmem_resp) pcnt = 0;
                end else begin
                    pmem_resp = 1'b0;
                end
            end
        end
        if (!done) begin
            checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
            exp_q.delete();
        end
        nextCycle();
        applyStimulus(1'b0, 1'b0, 4'b0000, valid, dirty, lru_way);
        pmem_resp = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        pmem_resp = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'b1010, 4'b0000, 4'b0000, 2'd0);
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_hit_way", 32'(hit_way), 32'd1);
        checkOutput("rst_mem_resp", 32'(mem_resp), 32'd0);
        checkOutput("rst_pmem_read", 32'(pmem_read), 32'd0);
        checkOutput("rst_pmem_write", 32'(pmem_write), 32'd0);
        checkOutput("rst_victim_way", 32'(victim_way), 32'd0);
        checkOutput("rst_lru_update", 32'(lru_update), 32'd0);
        checkOutput("rst_perf_hits", perf_hits, 32'd0);

        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd0);

        $display("[TB] reset during ALLOCATE");
        nextCycle();
        applyStimulus(1'b1, 1'b0, 4'b0000, 4'b1011, 4'b0000, 2'd0);
        nextCycle();
        nextCycle();
        #2;
        checkOutput("abort_pmem_read_up", 32'(pmem_read), 32'd1);
        nextCycle();
        rst = 1'b1;
        pmem_resp = 1'b1;
        #1;
        checkOutput("abort_pmem_read_drop", 32'(pmem_read), 32'd0);
        checkOutput("abort_line_we", 32'(line_we), 32'd0);
        checkOutput("abort_valid_we", 32'(valid_we), 32'd0);
        checkOutput("abort_dirty_we", 32'(dirty_we), 32'd0);
        checkOutput("abort_mem_resp", 32'(mem_resp), 32'd0);
        checkOutput("abort_victim_way", 32'(victim_way), 32'd0);
        checkOutput("abort_perf_misses", perf_misses, 32'd0);
        nextCycle();
        rst = 1'b0;
        pmem_resp = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd0);
        #2;
        checkOutput("abort_idle_pmem_read", 32'(pmem_read), 32'd0);

        $display("[TB] read hit");
        runTxn("rd_hit", 1'b1, 1'b0, 4'b0100, 4'b1111, 4'b0000, 2'd0, 5,
               mkExp(2'd2, 4'b0000, 4'b0000, 1'b0, 1, 1'b0, 1'b0, 4'b0000, 2'd0));

        $display("[TB] write hit");
        runTxn("wr_hit", 1'b0, 1'b1, 4'b0001, 4'b1111, 4'b0000, 2'd0, 5,
               mkExp(2'd0, 4'b0001, 4'b0001, 1'b1, 1, 1'b0, 1'b0, 4'b0000, 2'd0));

        $display("[TB] clean miss into invalid way");
        runTxn("clean_miss", 1'b1, 1'b0, 4'b0000, 4'b1011, 4'b0010, 2'd1, 5,
               mkExp(2'd2, 4'b0000, 4'b0000, 1'b0, 7, 1'b0, 1'b1, 4'b0100, 2'd2));

        $display("[TB] dirty miss with LRU victim");
        runTxn("dirty_miss", 1'b0, 1'b1, 4'b0000, 4'b1111, 4'b1000, 2'd3, 3,
               mkExp(2'd3, 4'b1000, 4'b1000, 1'b1, 8, 1'b1, 1'b1, 4'b1000, 2'd3));

        $display("[TB] read+write with multiple hit bits");
        runTxn("multi_hit_rw", 1'b1, 1'b1, 4'b1100, 4'b1111, 4'b0000, 2'd0, 5,
               mkExp(2'd2, 4'b0100, 4'b0100, 1'b1, 1, 1'b0, 1'b0, 4'b0000, 2'd3));

        #2;
        checkOutput("end_queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("perf_hits", perf_hits, EXP_HITS);
        checkOutput("perf_misses", perf_misses, EXP_MISSES);
        checkOutput("perf_wbs", perf_wbs, EXP_WBS);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
